booth_mul_arbiter: RTL and testbench
====================================

// Module: booth_mul_arbiter
// PURPOSE
//  Shares one pipelined signed booth_multiplier between two requesters.
//  Per-requester valid/ready operand channel; round-robin grant; max one issue/cycle.
//  Tag pipeline matched to multiplier latency routes each product back to its owner.
//  Per-requester result register held until acknowledged.
//  Sits between host-side emulation transactors and a single booth_multiplier instance.
// PARAMETERS
//  W            8   operand width; product width is 2*W, signed two's complement
//  MUL_LATENCY  1   clk edges from operands driven to product valid; legal range >= 1
// PORTS
//  clk              in   1    single clock, rising edge; also drives the multiplier
//  rst_n            in   1    asynchronous, active-low reset
//  req0_valid       in   1    requester 0 has operands
//  req0_ready       out  1    requester 0 operands accepted this cycle
//  req0_a           in   W    requester 0 multiplier (signed)
//  req0_b           in   W    requester 0 multiplicand (signed)
//  rsp0_valid       out  1    requester 0 product available
//  rsp0_product     out  2W   requester 0 product (signed)
//  rsp0_ack         in   1    requester 0 consumes product
//  req1_*/rsp1_*    --   --   identical set for requester 1
//  mul_multiplier   out  W    to booth_multiplier.multiplier (registered)
//  mul_multiplicand out  W    to booth_multiplier.multiplicand (registered)
//  mul_product      in   2W   from booth_multiplier.product
//  busy             out  1    any requester not IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all outputs 0; tag pipe cleared; both requesters IDLE.
//   - RR pointer set so requester 0 wins the first tie.
//  Per-requester FSM:
//   - IDLE   -> ISSUED on accept (valid & ready).
//   - ISSUED -> DONE when its tag exits the pipe.
//   - DONE   -> IDLE on rsp_ack.
//   - Max one outstanding op per requester; this is the backpressure mechanism.
//  reqN_ready (combinational):
//   - =1 only if FSM N is IDLE, reqN_valid=1, and N wins arbitration.
//   - Never asserted for both requesters in the same cycle.
//  Arbitration:
//   - Single eligible requester: it wins.
//   - Both eligible: the one not granted last wins.
//   - RR pointer updates only on an actual grant.
//  Issue at edge t0:
//   - mul_multiplier/mul_multiplicand <= granted a/b.
//   - Tag pipe stage0 <= {1, id}.
//   - No grant: operands hold last value; stage0 valid <= 0.
//  Tag pipe:
//   - MUL_LATENCY stages of {valid, id}, shifting every clk.
//   - Output stage valid in the cycle before edge t0+MUL_LATENCY.
//   - At that edge: rspN_product <= mul_product; rspN_valid <= 1; FSM -> DONE.
//   - rsp_valid is first high in the cycle after t0+MUL_LATENCY.
//   - Issue-to-issue throughput: 1/cycle when the two requesters alternate.
//  Response hold:
//   - rspN_valid and rspN_product held stable until the edge sampling rspN_ack=1 with rspN_valid=1.
//   - At that edge rspN_valid <= 0; rspN_product keeps its value.
//   - rspN_ack while rspN_valid=0 is ignored.
//  Simultaneous events:
//   - ack and a new reqN_valid in the same cycle: ready stays 0, since FSM is DONE.
//   - The new request is accepted no earlier than the next cycle.
//  Stalls:
//   - A requester stalled in DONE never blocks the other.
//   - Its tag slot has already drained, so the pipe never stalls.
//  Arithmetic:
//   - The block performs none; products pass through unmodified.
//   - Width is exactly 2W, sign preserved.
//  Reset mid-operation:
//   - In-flight tags and pending results are discarded.
//   - No rsp_valid appears after reset release for pre-reset requests.
//  busy = OR over both FSMs != IDLE; reset 0.
// TESTING
//  1 req0 a=3,b=-5, ack on rsp_valid:
//    -> rsp0_product=16'hFFF1, rsp_valid rises L edges after accept; req1 silent.
//  2 From reset, both valid in the same cycle (req0 -128*-128, req1 127*-128):
//    -> req0 granted first: 16'h4000; req1 granted next cycle: 16'hC080.
//  3 Both valid continuously with immediate acks:
//    -> grants alternate 0,1,0,1...; no requester starved; products match a*b.
//  4 rsp0_ack held low 10 cycles:
//    -> rsp0_valid/product stable, req0_ready=0; req1 still issued and answered.
//  5 rst_n pulsed low while both ops are in flight:
//    -> all outputs 0 immediately; no rsp_valid afterwards until new requests are accepted.
//  6 Ack pulses with rsp_valid=0, and ack coincident with a new valid:
//    -> spurious ack ignored; new op accepted exactly one cycle after the ack edge.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sharing of one pipelined signed multiplier between two requesters
module booth_mul_arbiter #(
  parameter int W           = 8,
  parameter int MUL_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           rsp0_valid,
  output logic [2*W-1:0] rsp0_product,
  input  logic           rsp0_ack,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp1_valid,
  output logic [2*W-1:0] rsp1_product,
  input  logic           rsp1_ack,
  output logic [W-1:0]   mul_multiplier,
  output logic [W-1:0]   mul_multiplicand,
  input  logic [2*W-1:0] mul_product,
  output logic           busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUED = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]           st0_q, st0_d, st1_q, st1_d;
  logic                 last_q, last_d;
  logic [MUL_LATENCY-1:0] tv_q, tid_q;
  logic [W-1:0]         mul_a_q, mul_b_q;
  logic                 rsp0_valid_q, rsp1_valid_q;
  logic [2*W-1:0]       rsp0_product_q, rsp1_product_q;

  logic elig0, elig1, grant0, grant1, any_grant, exit0, exit1;

  // last_q=1 means requester 1 was granted last, so requester 0 wins the next tie
  assign elig0     = (st0_q == S_IDLE) && req0_valid;
  assign elig1     = (st1_q == S_IDLE) && req1_valid;
  assign grant0    = elig0 && (!elig1 || last_q);
  assign grant1    = elig1 && (!elig0 || !last_q);
  assign any_grant = grant0 || grant1;

  assign exit0 = tv_q[MUL_LATENCY-1] && !tid_q[MUL_LATENCY-1];
  assign exit1 = tv_q[MUL_LATENCY-1] &&  tid_q[MUL_LATENCY-1];

  always_comb begin
    last_d = last_q;
    if (grant1)      last_d = 1'b1;
    else if (grant0) last_d = 1'b0;

    st0_d = st0_q;
    case (st0_q)
      S_IDLE:   if (grant0) st0_d = S_ISSUED;
      S_ISSUED: if (exit0) st0_d = S_DONE;
      S_DONE:   if (rsp0_ack && rsp0_valid_q) st0_d = S_IDLE;
      default:  st0_d = S_IDLE;
    endcase

    st1_d = st1_q;
    case (st1_q)
      S_IDLE:   if (grant1) st1_d = S_ISSUED;
      S_ISSUED: if (exit1) st1_d = S_DONE;
      S_DONE:   if (rsp1_ack && rsp1_valid_q) st1_d = S_IDLE;
      default:  st1_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q          <= S_IDLE;
      st1_q          <= S_IDLE;
      last_q         <= 1'b1;
      tv_q           <= '0;
      tid_q          <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp0_product_q <= '0;
      rsp1_product_q <= '0;
    end else begin
      st0_q  <= st0_d;
      st1_q  <= st1_d;
      last_q <= last_d;
      // Tag pipe mirrors the multiplier latency so the exiting tag names the product's owner
      tv_q[0]  <= any_grant;
      tid_q[0] <= grant1;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
      if (any_grant) begin
        mul_a_q <= grant1 ? req1_a : req0_a;
        mul_b_q <= grant1 ? req1_b : req0_b;
      end
      if (exit0) begin
        rsp0_valid_q   <= 1'b1;
        rsp0_product_q <= mul_product;
      end else if (rsp0_valid_q && rsp0_ack) begin
        rsp0_valid_q <= 1'b0;
      end
      if (exit1) begin
        rsp1_valid_q   <= 1'b1;
        rsp1_product_q <= mul_product;
      end else if (rsp1_valid_q && rsp1_ack) begin
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  assign req0_ready       = grant0;
  assign req1_ready       = grant1;
  assign rsp0_valid       = rsp0_valid_q;
  assign rsp1_valid       = rsp1_valid_q;
  assign rsp0_product     = rsp0_product_q;
  assign rsp1_product     = rsp1_product_q;
  assign mul_multiplier   = mul_a_q;
  assign mul_multiplicand = mul_b_q;
  assign busy             = (st0_q != S_IDLE) || (st1_q != S_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;
  localparam int W = 8;
  localparam int L = 1;

  logic clk, rst_n;
  logic req0_valid, req0_ready, rsp0_valid, rsp0_ack;
  logic req1_valid, req1_ready, rsp1_valid, rsp1_ack;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, mul_multiplier, mul_multiplicand;
  logic [2*W-1:0] rsp0_product, rsp1_product, mul_product;
  logic busy;

  booth_mul_arbiter #(.W(W), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_product(rsp0_product), .rsp0_ack(rsp0_ack),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_product(rsp1_product), .rsp1_ack(rsp1_ack),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product), .busy(busy)
  );

  // Behavioural multiplier: product appears L edges after the operands are driven
  logic [2*W-1:0] raw_product;
  assign raw_product = 16'($signed(mul_multiplier) * $signed(mul_multiplicand));
  generate
    if (L == 1) begin : g_comb
      assign mul_product = raw_product;
    end else begin : g_pipe
      logic [2*W-1:0] pipe [L-1];
      always @(posedge clk) begin
        pipe[0] <= raw_product;
        for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign mul_product = pipe[L-2];
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Reference model: per requester, "owns an outstanding op", the cycle its result becomes visible, and its value
  bit          bm [2];
  int          arr [2];
  logic [15:0] em [2];
  bit          lg;
  int          cyc = 0;

  function automatic logic [15:0] prod(logic [7:0] a, logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic model_reset();
    bm[0] = 0; bm[1] = 0; lg = 1'b1;
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge, advances model past the edge
  task automatic drive_cycle(input bit v0, input logic [7:0] a0, input logic [7:0] b0, input bit k0,
                             input bit v1, input logic [7:0] a1, input logic [7:0] b1, input bit k1,
                             output bit r0, output bit r1);
    bit e0, e1, g0, g1, rv0, rv1;
    req0_valid = v0; req0_a = a0; req0_b = b0; rsp0_ack = k0;
    req1_valid = v1; req1_a = a1; req1_b = b1; rsp1_ack = k1;
    @(negedge clk);
    rv0 = bm[0] && cyc >= arr[0];
    rv1 = bm[1] && cyc >= arr[1];
    e0 = v0 && !bm[0];
    e1 = v1 && !bm[1];
    if (e0 && e1) begin
      g0 = (lg == 1'b1);
      g1 = !g0;
    end else begin
      g0 = e0;
      g1 = e1;
    end
    r0 = req0_ready;
    r1 = req1_ready;
    chk("ready0", 32'(req0_ready), 32'(g0));
    chk("ready1", 32'(req1_ready), 32'(g1));
    chk("rsp_valid0", 32'(rsp0_valid), 32'(rv0));
    chk("rsp_valid1", 32'(rsp1_valid), 32'(rv1));
    if (rv0) chk("product0", 32'(rsp0_product), 32'(em[0]));
    if (rv1) chk("product1", 32'(rsp1_product), 32'(em[1]));
    chk("busy", 32'(busy), 32'(bm[0] || bm[1]));
    @(posedge clk);
    cyc++;
    if (rv0 && k0) bm[0] = 0;
    if (rv1 && k1) bm[1] = 0;
    if (g0) begin bm[0] = 1; arr[0] = cyc + L; em[0] = prod(a0, b0); lg = 1'b0; end
    if (g1) begin bm[1] = 1; arr[1] = cyc + L; em[1] = prod(a1, b1); lg = 1'b1; end
    #1;
  endtask

  task automatic idle(input bit k0, input bit k1);
    bit r0, r1;
    drive_cycle(0, 8'h00, 8'h00, k0, 0, 8'h00, 8'h00, k1, r0, r1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (!busy && !rsp0_valid && !rsp1_valid) break;
      idle(rsp0_valid, rsp1_valid);
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ack = 0; rsp1_ack = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    #1;
    model_reset();
    chk("rst_outputs", {rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy, 27'd0}, 32'd0);
    chk("rst_products", {rsp0_product, rsp1_product}, 32'd0);
    chk("rst_mul_ops", {16'd0, mul_multiplier, mul_multiplicand}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit r0, r1, v, rv;
    int n, prev, g0cnt, g1cnt, acks1;
    logic [15:0] p0;
    logic [7:0] ra, rb;

    vecs[0] = '{1'b0, 8'h03, 8'hFB, 16'hFFF1};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2] = '{1'b0, 8'h7F, 8'h80, 16'hC080};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[4] = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
    vecs[5] = '{1'b1, 8'h00, 8'hB3, 16'h0000};
    vecs[6] = '{1'b0, 8'h80, 8'h7F, 16'hC080};
    vecs[7] = '{1'b1, 8'h01, 8'hFF, 16'hFFFF};

    apply_reset();

    // Both valid straight out of reset: requester 0 wins, then requester 1
    drive_cycle(1, 8'h80, 8'h80, 0, 1, 8'h7F, 8'h80, 0, r0, r1);
    chk("tie_first_r0", 32'(r0), 32'd1);
    drive_cycle(0, 8'h00, 8'h00, 0, 1, 8'h7F, 8'h80, 0, r0, r1);
    chk("tie_second_r1", 32'(r1), 32'd1);
    for (int i = 0; i < 10 && !(rsp0_valid && rsp1_valid); i++) idle(0, 0);
    chk("tie_prod0", 32'(rsp0_product), 32'h4000);
    chk("tie_prod1", 32'(rsp1_product), 32'hC080);
    drain();

    // Table vectors: single requester, latency and product against constants
    foreach (vecs[k]) begin
      if (vecs[k].id == 1'b0) drive_cycle(1, vecs[k].a, vecs[k].b, 0, 0, 8'h00, 8'h00, 0, r0, r1);
      else                    drive_cycle(0, 8'h00, 8'h00, 0, 1, vecs[k].a, vecs[k].b, 0, r0, r1);
      chk("vec_ready", 32'(vecs[k].id ? r1 : r0), 32'd1);
      n = 0;
      rv = vecs[k].id ? rsp1_valid : rsp0_valid;
      while (!rv && n < 20) begin
        idle(0, 0);
        n++;
        rv = vecs[k].id ? rsp1_valid : rsp0_valid;
      end
      chk("vec_latency", 32'(n), 32'(L));
      chk("vec_other_silent", 32'(vecs[k].id ? rsp0_valid : rsp1_valid), 32'd0);
      chk("vec_product", 32'(vecs[k].id ? rsp1_product : rsp0_product), 32'(vecs[k].exp));
      idle(!vecs[k].id, vecs[k].id);
      chk("vec_cleared", 32'(vecs[k].id ? rsp1_valid : rsp0_valid), 32'd0);
      chk("vec_product_kept", 32'(vecs[k].id ? rsp1_product : rsp0_product), 32'(vecs[k].exp));
    end

    // Both requesters always valid, immediate acks: grants must alternate
    prev = -1; g0cnt = 0; g1cnt = 0;
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1, 8'($urandom), 8'($urandom), rsp0_valid,
                  1, 8'($urandom), 8'($urandom), rsp1_valid, r0, r1);
      if (r0 || r1) begin
        if (prev >= 0) chk("alternate", 32'(r1), 32'(prev == 0));
        prev = r1 ? 1 : 0;
        if (r0) g0cnt++; else g1cnt++;
      end
    end
    chk("no_starve", 32'(g0cnt >= 10 && g1cnt >= 10), 32'd1);
    drain();

    // Requester 0 holds its result for 10 cycles; requester 1 keeps working
    drive_cycle(1, 8'hFD, 8'h09, 0, 0, 8'h00, 8'h00, 0, r0, r1);
    for (int i = 0; i < 10 && !rsp0_valid; i++) idle(0, 0);
    p0 = rsp0_product;
    chk("hold_initial", 32'(p0), 32'hFFE5);
    acks1 = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp1_valid) acks1++;
      drive_cycle(1, 8'($urandom), 8'($urandom), 0, 1, 8'($urandom), 8'($urandom), rsp1_valid, r0, r1);
      chk("hold_ready0", 32'(r0), 32'd0);
      chk("hold_stable", {15'd0, rsp0_valid, rsp0_product}, {15'd0, 1'b1, p0});
    end
    chk("hold_req1_served", 32'(acks1 >= 2), 32'd1);
    drain();

    // Reset while both are in flight
    drive_cycle(1, 8'h11, 8'h22, 0, 1, 8'h33, 8'h44, 0, r0, r1);
    drive_cycle(0, 8'h00, 8'h00, 0, 1, 8'h33, 8'h44, 0, r0, r1);
    apply_reset();
    for (int i = 0; i < 6; i++) idle(0, 0);
    chk("post_reset_quiet", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);

    // Spurious acks, then ack coincident with a new request
    idle(1, 1);
    chk("spurious_idle", 32'(rsp0_valid), 32'd0);
    drive_cycle(1, 8'h05, 8'h06, 0, 0, 8'h00, 8'h00, 0, r0, r1);
    chk("sp_accept", 32'(r0), 32'd1);
    for (int i = 0; i < L - 1; i++) idle(1, 0);
    idle(1, 0);
    chk("sp_ack_ignored", {15'd0, rsp0_valid, rsp0_product}, {15'd0, 1'b1, 16'd30});
    drive_cycle(1, 8'h07, 8'hFE, 1, 0, 8'h00, 8'h00, 0, r0, r1);
    chk("ack_with_valid_ready", 32'(r0), 32'd0);
    drive_cycle(1, 8'h07, 8'hFE, 0, 0, 8'h00, 8'h00, 0, r0, r1);
    chk("accept_after_ack", 32'(r0), 32'd1);
    drain();
    chk("after_ack_product", 32'(rsp0_product), 32'hFFF2);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      v = ($urandom_range(0, 3) != 0);
      drive_cycle(v, ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 1'($urandom), r0, r1);
      chk("never_both_ready", 32'(r0 && r1), 32'd0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
